// File: rtl/alu_pkg.sv
// Flag bit positions, condition code encodings and the flag nibble type shared
// by the flag/condition block and its stack.
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

  typedef enum logic [3:0] {
    COND_EQ = 4'd0,  COND_NE = 4'd1,  COND_CS = 4'd2,  COND_CC = 4'd3,
    COND_MI = 4'd4,  COND_PL = 4'd5,  COND_VS = 4'd6,  COND_VC = 4'd7,
    COND_HI = 4'd8,  COND_LS = 4'd9,  COND_GE = 4'd10, COND_LT = 4'd11,
    COND_GT = 4'd12, COND_LE = 4'd13, COND_AL = 4'd14, COND_NV = 4'd15
  } cond_e;

endpackage

// File: rtl/alu_flag_stack.sv
// LIFO of saved flag nibbles. Misuse (push+pop together, push when full,
// pop when empty) leaves the stack untouched and sets a sticky error.
module alu_flag_stack
  import alu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  flags_t din,
  output flags_t top,
  output logic   pop_ok,
  output logic   full,
  output logic   empty,
  output logic   err
);

  flags_t           mem [STACK_DEPTH];
  logic [PTR_W:0]   depth;
  logic [PTR_W-1:0] top_idx;
  logic             push_ok;
  logic             misuse;

  assign full    = (depth == (PTR_W+1)'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign top_idx = PTR_W'(depth - 1'b1);
  assign top     = mem[top_idx];
  assign push_ok = push & ~pop & ~full;
  assign pop_ok  = pop & ~push & ~empty;
  assign misuse  = (push & pop) | (push & full) | (pop & empty);

  // Depth counter and sticky misuse flag; depth never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      depth <= '0;
      err   <= 1'b0;
    end else begin
      if (push_ok)     depth <= depth + 1'b1;
      else if (pop_ok) depth <= depth - 1'b1;
      if (misuse)      err   <= 1'b1;
    end
  end

  // Storage needs no reset: entries above depth are never read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[depth[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/alu_flag_cond_unit.sv
// Architectural NZCV register with same-cycle forwarding, a registered
// condition evaluator behind a valid/ready handshake, and a flag save stack.
module alu_flag_cond_unit
  import alu_pkg::*;
#(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_we,
  input  logic [3:0] flag_in,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       pass_valid,
  output logic       pass,
  input  logic       pass_ready,
  input  logic       push,
  input  logic       pop,
  output logic [3:0] flags,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       err
);

  function automatic logic cond_eval(input logic [3:0] code, input flags_t f);
    logic n, z, c, v;
    n = f[FLAG_N]; z = f[FLAG_Z]; c = f[FLAG_C]; v = f[FLAG_V];
    case (cond_e'(code))
      COND_EQ: return z;
      COND_NE: return ~z;
      COND_CS: return c;
      COND_CC: return ~c;
      COND_MI: return n;
      COND_PL: return ~n;
      COND_VS: return v;
      COND_VC: return ~v;
      COND_HI: return c & ~z;
      COND_LS: return ~c | z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return ~z & (n == v);
      COND_LE: return z | (n != v);
      COND_AL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  flags_t eff;
  flags_t stk_top;
  logic   pop_ok;
  logic   accept;

  // Queries see this cycle's ALU write, not a same-cycle pop.
  assign eff        = flag_we ? flag_in : flags;
  assign cond_ready = ~pass_valid | pass_ready;
  assign accept     = cond_valid & cond_ready;

  alu_flag_stack #(.STACK_DEPTH(STACK_DEPTH), .PTR_W(PTR_W)) u_stack (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .din    (eff),
    .top    (stk_top),
    .pop_ok (pop_ok),
    .full   (stack_full),
    .empty  (stack_empty),
    .err    (err)
  );

  // Flag register: a successful pop outranks the ALU write.
  always_ff @(posedge clk) begin
    if (!rst_n)       flags <= '0;
    else if (pop_ok)  flags <= stk_top;
    else if (flag_we) flags <= flag_in;
  end

  // Result slot: a new accept may overwrite a result drained this cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      pass_valid <= 1'b1;
      pass       <= cond_eval(cond_code, eff);
    end else if (pass_ready) begin
      pass_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_flag_cond_unit.sv
module tb_alu_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst_n, flag_we, cond_valid, pass_ready, push, pop;
  logic [3:0] flag_in, cond_code;
  logic       cond_ready, pass_valid, pass, stack_full, stack_empty, err;
  logic [3:0] flags;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_flag_cond_unit #(.STACK_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .flag_in(flag_in),
    .cond_valid(cond_valid), .cond_code(cond_code), .cond_ready(cond_ready),
    .pass_valid(pass_valid), .pass(pass), .pass_ready(pass_ready),
    .push(push), .pop(pop), .flags(flags), .stack_full(stack_full),
    .stack_empty(stack_empty), .err(err)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    flag_we = 0; flag_in = '0; cond_valid = 0; cond_code = '0;
    pass_ready = 1; push = 0; pop = 0;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; step(); rst_n = 1; step();
    total++; if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags); else passed++;
    total++; if (pass_valid !== 1'b0) $display("FAIL reset_pass_valid got=%b exp=0", pass_valid); else passed++;
    total++; if (stack_empty !== 1'b1) $display("FAIL reset_empty got=%b exp=1", stack_empty); else passed++;
    total++; if (stack_full !== 1'b0) $display("FAIL reset_full got=%b exp=0", stack_full); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else passed++;
    total++; if (cond_ready !== 1'b1) $display("FAIL reset_cond_ready got=%b exp=1", cond_ready); else passed++;
  endtask

  task automatic test_forward();
    flag_we = 1; flag_in = 4'b0100; cond_valid = 1; cond_code = 4'd0;
    step(); idle();
    total++; if (pass_valid !== 1'b1) $display("FAIL fwd_pass_valid got=%b exp=1", pass_valid); else passed++;
    total++; if (pass !== 1'b1) $display("FAIL fwd_pass got=%b exp=1", pass); else passed++;
    total++; if (flags !== 4'b0100) $display("FAIL fwd_flags got=%b exp=0100", flags); else passed++;
    step();
  endtask

  // Sweep all 16 codes back-to-back against a given flag value.
  task automatic sweep(input logic [3:0] f, input logic [15:0] exp);
    flag_we = 1; flag_in = f; step(); idle();
    for (int i = 0; i < 16; i++) begin
      cond_valid = 1; cond_code = 4'(i); step();
      total++;
      if (pass_valid !== 1'b1 || pass !== exp[i])
        $display("FAIL cond flags=%b code=%0d got v=%b p=%b exp v=1 p=%b", f, i, pass_valid, pass, exp[i]);
      else passed++;
    end
    idle(); step();
    total++; if (pass_valid !== 1'b0) $display("FAIL drain_pass_valid got=%b exp=0", pass_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    sweep(4'b1001, 16'h565A);
    sweep(4'b0110, 16'h66A5);
    sweep(4'b0010, 16'h55A6);
  endtask

  task automatic test_stall();
    flag_we = 1; flag_in = 4'b1001; step(); idle();
    pass_ready = 0; cond_valid = 1; cond_code = 4'd10; step();
    total++; if (pass_valid !== 1'b1 || pass !== 1'b1) $display("FAIL stall_first got v=%b p=%b exp v=1 p=1", pass_valid, pass); else passed++;
    cond_code = 4'd11; #1;
    total++; if (cond_ready !== 1'b0) $display("FAIL stall_ready got=%b exp=0", cond_ready); else passed++;
    step();
    total++; if (pass_valid !== 1'b1 || pass !== 1'b1) $display("FAIL stall_hold got v=%b p=%b exp v=1 p=1", pass_valid, pass); else passed++;
    pass_ready = 1; #1;
    total++; if (cond_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", cond_ready); else passed++;
    step();
    total++; if (pass_valid !== 1'b1 || pass !== 1'b0) $display("FAIL stall_next got v=%b p=%b exp v=1 p=0", pass_valid, pass); else passed++;
    idle(); step();
    total++; if (pass_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", pass_valid); else passed++;
  endtask

  task automatic test_stack();
    logic [3:0] vals [4];
    vals[0] = 4'b0010; vals[1] = 4'b1000; vals[2] = 4'b0001; vals[3] = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      flag_we = 1; flag_in = vals[i]; push = 1; step();
    end
    idle();
    total++; if (stack_full !== 1'b1) $display("FAIL stack_full got=%b exp=1", stack_full); else passed++;
    total++; if (err !== 1'b0) $display("FAIL stack_err_before got=%b exp=0", err); else passed++;
    push = 1; step(); idle();
    total++; if (err !== 1'b1) $display("FAIL push_full_err got=%b exp=1", err); else passed++;
    total++; if (flags !== 4'b0100) $display("FAIL push_full_flags got=%b exp=0100", flags); else passed++;
    for (int i = 3; i >= 0; i--) begin
      flag_we = 1; flag_in = 4'b1111; pop = 1; step(); idle();
      total++; if (flags !== vals[i]) $display("FAIL pop%0d got=%b exp=%b", 3 - i, flags, vals[i]); else passed++;
    end
    total++; if (stack_empty !== 1'b1) $display("FAIL pop_empty got=%b exp=1", stack_empty); else passed++;
    flag_we = 1; flag_in = 4'b1100; pop = 1; step(); idle();
    total++; if (flags !== 4'b1100) $display("FAIL pop_empty_flags got=%b exp=1100", flags); else passed++;
    total++; if (err !== 1'b1) $display("FAIL pop_empty_err got=%b exp=1", err); else passed++;
  endtask

  task automatic test_push_pop();
    rst_n = 0; step(); rst_n = 1;
    flag_we = 1; flag_in = 4'b0011; push = 1; step();
    flag_in = 4'b0101; step();
    flag_in = 4'b1111; pop = 1; step(); idle();
    total++; if (flags !== 4'b1111) $display("FAIL pp_flags got=%b exp=1111", flags); else passed++;
    total++; if (err !== 1'b1) $display("FAIL pp_err got=%b exp=1", err); else passed++;
    pop = 1; step(); idle();
    total++; if (flags !== 4'b0101 || stack_empty !== 1'b0) $display("FAIL pp_pop1 got=%b/%b exp=0101/0", flags, stack_empty); else passed++;
    pop = 1; step(); idle();
    total++; if (flags !== 4'b0011 || stack_empty !== 1'b1) $display("FAIL pp_pop2 got=%b/%b exp=0011/1", flags, stack_empty); else passed++;
  endtask

  task automatic test_reset_mid();
    flag_we = 1; flag_in = 4'b1010; push = 1; step(); idle();
    pass_ready = 0; cond_valid = 1; cond_code = 4'd14; step();
    total++; if (pass_valid !== 1'b1 || pass !== 1'b1) $display("FAIL mid_pending got v=%b p=%b exp v=1 p=1", pass_valid, pass); else passed++;
    rst_n = 0; step(); rst_n = 1; idle(); #1;
    total++; if (pass_valid !== 1'b0 || pass !== 1'b0) $display("FAIL mid_pass got v=%b p=%b exp v=0 p=0", pass_valid, pass); else passed++;
    total++; if (flags !== 4'b0000 || err !== 1'b0) $display("FAIL mid_flags_err got=%b/%b exp=0000/0", flags, err); else passed++;
    total++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) $display("FAIL mid_stack got e=%b f=%b exp e=1 f=0", stack_empty, stack_full); else passed++;
  endtask

  initial begin
    idle(); rst_n = 0;
    test_reset();
    test_forward();
    test_back_to_back();
    test_stall();
    test_stack();
    test_push_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_flag_cond_unit.md
Name: alu_flag_cond_unit

Overview:
- Consumer end of the ALU flag interface: holds the architectural [N,Z,C,V] register written by the ADD/SUB/logic units when S=1.
- Evaluates 4-bit condition codes against those flags for conditional execution/branching, with a valid/ready handshake and a registered result.
- Provides a small flag save/restore stack for interrupt/call entry.
- Sits between the MASTER_ALU flag outputs and the control/branch unit.

Parameters:
- STACK_DEPTH, 4, number of saved flag entries (power of two, >=2)
- PTR_W, 2, log2(STACK_DEPTH)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flag_we  in  1  ALU S bit: write flag_in this cycle
- flag_in  in  4  ALU New_Flag, bit3=N, bit2=Z, bit1=C, bit0=V
- cond_valid  in  1  condition query present
- cond_code  in  4  condition to evaluate
- cond_ready  out  1  query accepted when cond_valid & cond_ready
- pass_valid  out  1  result available
- pass  out  1  1 = condition true
- pass_ready  in  1  consumer takes result
- push  in  1  save effective flags onto stack
- pop  in  1  restore flags from stack top
- flags  out  4  current flag register
- stack_full  out  1  depth == STACK_DEPTH
- stack_empty  out  1  depth == 0
- err  out  1  sticky protocol error

Behaviour:
- One clock; reset is synchronous and active-low: on clk edge with rst_n=0 -> flags=4'b0000, pass_valid=0, pass=0, stack depth 0 (stack_empty=1, stack_full=0), err=0. Reset mid-query discards any held result.
- Effective flags eff = flag_we ? flag_in : flags (same-cycle forwarding).
- Flag register next value, priority: valid pop (stack non-empty, push=0) -> stack top; else flag_we -> flag_in; else hold.
- Condition map (ARM order): 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0 (reserved, never passes).
- Query evaluated against eff (not against a same-cycle pop's restored value).
- Handshake: cond_ready = !pass_valid | pass_ready (combinational). On accept, pass/pass_valid register next edge (latency 1). pass_valid stays 1 and pass stable until pass_ready=1; if accept and drain coincide, new result replaces old with pass_valid held at 1 (back-to-back, 1 query/cycle throughput).
- Stack: LIFO, push writes eff at top, depth+1. Pop reads top, depth-1.
- push & pop same cycle: stack unchanged, flags follow flag_we rule, err<=1.
- push when full: ignored, err<=1. Pop when empty: ignored, err<=1, flag_we still applies.
- err sticky, cleared only by reset.
- Depth counter width PTR_W+1; no wrap-around permitted.

Decomposition:
- Shared package alu_pkg: flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), condition code constants COND_EQ..COND_NV, 4-bit flag typedef.
- One sub-module: alu_flag_stack (LIFO with depth, full/empty, error on misuse). Condition decode stays a combinational function in the top.

Test Plan:
- Reset then idle -> flags=0000, pass_valid=0, stack_empty=1, err=0, cond_ready=1.
- flag_we=1, flag_in=0100 with cond_valid=1, cond_code=EQ same cycle -> next cycle pass_valid=1, pass=1 (forwarding), flags=0100.
- flags=1001 (N=1, V=1): query GE then LT back-to-back with pass_ready=1 -> pass 1 then 0 on consecutive cycles. Query 15 -> pass=0.
- Hold pass_ready=0 with result pending, assert new query -> cond_ready=0, pass unchanged. Release pass_ready -> queued query accepted, result next cycle.
- Push flags 0010, 1000, 0001, 0100 -> stack_full=1. Fifth push -> err=1. Four pops restore 0100, 0001, 1000, 0010 to flags. Fifth pop with flag_we=1, flag_in=1100 -> flags=1100, err stays 1.
- Push & pop same cycle at depth 2 -> depth stays 2, err=1. Assert rst_n=0 while pass_valid=1 -> all outputs back to reset values.
